// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state instruction sequencer driving an external ALU and register-file write-back.
// Optional macro ALU_SEQUENCER_ZERO_FLAG_EN adds a zero_flag output updated on ALU write-backs.
`default_nettype none

module alu_sequencer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [3:0]            rs_addr,
   output logic [3:0]            rt_addr,
   output logic [2:0]            FS,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic                  wb_en,
   output logic [3:0]            wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  illegal,
   output logic                  busy
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
   ,
   output logic                  zero_flag
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_WB     = 2'd3
   } state_t;

   state_t                r_state;
   logic [15:0]           r_instr;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_ready;
   logic                  r_busy;
   logic [3:0]            r_rs_addr;
   logic [3:0]            r_rt_addr;
   logic [2:0]            r_fs;
   logic                  r_wb_en;
   logic [3:0]            r_wb_addr;
   logic                  r_illegal;

   logic [3:0]            w_opcode;
   logic [3:0]            w_rd;
   logic                  w_rd_nz;
   logic [DATA_WIDTH-1:0] w_imm_sext;

   assign w_opcode   = r_instr[15:12];
   assign w_rd       = r_instr[11:8];
   assign w_rd_nz    = (w_rd != 4'd0);
   assign w_imm_sext = {{(DATA_WIDTH-8){r_instr[7]}}, r_instr[7:0]};

`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
   logic r_zero_flag;
   assign zero_flag = r_zero_flag;
`endif

   // The result register doubles as write-back data; it only moves when a real
   // (rd != 0) write occurs, so wb_data/wb_addr hold between write-backs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_instr     <= 16'd0;
         r_result    <= '0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_rs_addr   <= 4'd0;
         r_rt_addr   <= 4'd0;
         r_fs        <= 3'd0;
         r_wb_en     <= 1'b0;
         r_wb_addr   <= 4'd0;
         r_illegal   <= 1'b0;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
         r_zero_flag <= 1'b0;
`endif
      end else begin
         r_wb_en   <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_instr   <= instr;
                  r_rs_addr <= instr[7:4];
                  r_rt_addr <= instr[3:0];
                  if (!instr[15])
                     r_fs <= instr[14:12];
                  r_illegal <= instr[15] && (instr[14:12] != 3'd0);
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!w_opcode[3]) begin
                  r_state <= S_EXEC;
               end else if (w_opcode == 4'd8) begin
                  r_wb_en <= w_rd_nz;
                  if (w_rd_nz) begin
                     r_wb_addr <= w_rd;
                     r_result  <= w_imm_sext;
                  end
                  r_state <= S_WB;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_EXEC: begin
               r_wb_en <= w_rd_nz;
               if (w_rd_nz) begin
                  r_wb_addr   <= w_rd;
                  r_result    <= alu_result;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
                  r_zero_flag <= (alu_result == '0);
`endif
               end
               r_state <= S_WB;
            end
            S_WB: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_ready = r_ready;
   assign busy        = r_busy;
   assign rs_addr     = r_rs_addr;
   assign rt_addr     = r_rt_addr;
   assign FS          = r_fs;
   assign wb_en       = r_wb_en;
   assign wb_addr     = r_wb_addr;
   assign wb_data     = r_result;
   assign illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus random instruction stream checked against a per-instruction timing model.
`default_nettype none

module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr = 16'd0;
   logic        instr_valid = 1'b0;
   logic [15:0] alu_result = 16'd0;
   logic        instr_ready;
   logic [3:0]  rs_addr;
   logic [3:0]  rt_addr;
   logic [2:0]  FS;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        illegal;
   logic        busy;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
   logic        zero_flag;
`endif

   alu_sequencer #(.DATA_WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .FS          (FS),
      .alu_result  (alu_result),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .illegal     (illegal),
      .busy        (busy)
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
      ,
      .zero_flag   (zero_flag)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  m_fs = 3'd0;
   logic        m_zf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string ctx);
      chk({ctx, "_ready"},   32'(instr_ready), 32'd1);
      chk({ctx, "_busy"},    32'(busy),        32'd0);
      chk({ctx, "_wb_en"},   32'(wb_en),       32'd0);
      chk({ctx, "_illegal"}, 32'(illegal),     32'd0);
      chk({ctx, "_FS"},      32'(FS),          32'd0);
      chk({ctx, "_rs"},      32'(rs_addr),     32'd0);
      chk({ctx, "_rt"},      32'(rt_addr),     32'd0);
      chk({ctx, "_wb_addr"}, 32'(wb_addr),     32'd0);
      chk({ctx, "_wb_data"}, 32'(wb_data),     32'd0);
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
      chk({ctx, "_zf"},      32'(zero_flag),   32'd0);
`endif
   endtask

   // Called at a falling edge with the sequencer idle; returns at a falling edge, idle.
   // abort_k > 0 pulls reset during cycle abort_k after the accept.
   task automatic do_instr(input logic [15:0] ins, input bit noisy, input bit fix,
                           input logic [15:0] fixval, input int abort_k);
      int          op;
      int          len;
      int          wbk;
      bit          rd_nz;
      bit          exp_wb;
      logic [15:0] captured;
      logic [15:0] exp_data;
      op       = int'(ins[15:12]);
      rd_nz    = (ins[11:8] != 4'd0);
      captured = 16'd0;
      if (op < 8) begin
         len = 4; wbk = 3;
      end else if (op == 8) begin
         len = 3; wbk = 2;
      end else begin
         len = 2; wbk = -1;
      end
      chk("ready_before_accept", 32'(instr_ready), 32'd1);
      instr       = ins;
      instr_valid = 1'b1;
      alu_result  = fix ? fixval : 16'($urandom);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (noisy) instr = 16'($urandom);
            else       instr_valid = 1'b0;
            if (op < 8) m_fs = ins[14:12];
         end
         alu_result = fix ? fixval : 16'($urandom);
         if (k == 2) captured = alu_result;
         if (k == abort_k) begin
            rst_n       = 1'b0;
            instr_valid = 1'b0;
            #1;
            check_reset_vals("abort");
            m_fs = 3'd0;
            m_zf = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               chk("post_abort_wb_en", 32'(wb_en),       32'd0);
               chk("post_abort_ready", 32'(instr_ready), 32'd1);
            end
            return;
         end
         exp_wb = (k == wbk) && rd_nz;
         chk("busy",    32'(busy),        32'(k < len));
         chk("ready",   32'(instr_ready), 32'(k == len));
         chk("illegal", 32'(illegal),     32'((op > 8) && (k == 1)));
         chk("wb_en",   32'(wb_en),       32'(exp_wb));
         chk("FS",      32'(FS),          32'(m_fs));
         if (k == 1) begin
            chk("rs_addr", 32'(rs_addr), 32'(ins[7:4]));
            chk("rt_addr", 32'(rt_addr), 32'(ins[3:0]));
         end
         if (exp_wb) begin
            exp_data = (op == 8) ? {{8{ins[7]}}, ins[7:0]} : captured;
            chk("wb_addr", 32'(wb_addr), 32'(ins[11:8]));
            chk("wb_data", 32'(wb_data), 32'(exp_data));
         end
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
         if (k == len) begin
            if (op < 8 && rd_nz) m_zf = (captured == 16'd0);
            chk("zero_flag", 32'(zero_flag), 32'(m_zf));
         end
`endif
      end
      instr_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("release");

      do_instr(16'h0123, 1'b0, 1'b1, 16'h0007, 0);
      do_instr(16'h85F0, 1'b0, 1'b0, 16'h0000, 0);
      do_instr(16'h9000, 1'b0, 1'b0, 16'h0000, 0);
      do_instr(16'h1012, 1'b1, 1'b0, 16'h0000, 0);
      do_instr(16'h1012, 1'b1, 1'b0, 16'h0000, 0);
      do_instr(16'h0123, 1'b0, 1'b1, 16'h0007, 2);
      do_instr(16'h8A7F, 1'b1, 1'b0, 16'h0000, 0);
      do_instr(16'hF3AB, 1'b1, 1'b0, 16'h0000, 0);
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
      do_instr(16'h4456, 1'b0, 1'b1, 16'h0000, 0);
      do_instr(16'h8200, 1'b0, 1'b0, 16'h0000, 0);
      chk("zf_after_li", 32'(zero_flag), 32'd1);
`endif

      for (int i = 0; i < 60; i++) begin
         do_instr(16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 16'd0,
                  ($urandom_range(0, 19) == 0) ? 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
